// File: rtl/sccb_req_arbiter.sv
// sccb_req_arbiter: two-port arbiter in front of a single SCCB write engine.
// Port A is the init-LUT sequencer. Port B is runtime control.
// Port B is held off until init_done is high. After that, ties between the
// ports are broken round-robin.
// Each granted request becomes one 24-bit {SLAVE_ADDR, reg, value} write.
// The write is handed to the engine with a REQ/BUSY handshake on a
// synchronized copy of SCCB_busy.
// Optional feature: define SCCB_ARB_TIMEOUT_EN to bound each transaction to
// TIMEOUT_CYC cycles. A transaction that times out is acked with ack_err.
module sccb_req_arbiter #(
  parameter logic [7:0]  SLAVE_ADDR  = 8'h42,
  parameter logic [19:0] TIMEOUT_CYC = 20'd600000
) (
  input  logic        S_CLK,
  input  logic        RST,
  input  logic        init_done,
  input  logic        a_req,
  input  logic [15:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [15:0] b_data,
  output logic        b_ack,
  output logic        ack_err,
  output logic        SCCB_req,
  output logic [23:0] data_in,
  input  logic        SCCB_busy,
  output logic        owner,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, next_state;
  logic   busy_meta, busy_s;
  logic   rr_last_b;     // 1 = port B was served last
  logic   grant_a, grant_b;
  logic   timeout;
  logic   to_err;

  // Port B is grantable only after init. On a tie, the port not served last wins.
  assign grant_a = a_req && (!init_done || !b_req || rr_last_b);
  assign grant_b = init_done && b_req && (!a_req || !rr_last_b);

  // Two-flop synchronizer for the engine busy flag, which comes from the slow clock domain.
  always_ff @(posedge S_CLK) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would make busy_s collapse into busy_meta.
    if (RST) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= SCCB_busy;
      busy_s    <= busy_meta;
    end
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [19:0] to_cnt;

  assign timeout = (state == S_REQ || state == S_BUSY) && (to_cnt == TIMEOUT_CYC);

  // Per-transaction cycle counter. It clears on grant, counts during REQ and BUSY, and latches the error flag on expiry.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state == S_IDLE) begin
      if (grant_a || grant_b) begin
        to_cnt <= '0;
        to_err <= 1'b0;
      end
    end else if (state == S_REQ || state == S_BUSY) begin
      if (timeout) begin
        to_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 20'd1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign to_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case statement, so no path leaves it unassigned and no latch is inferred.
    next_state = state;
    SCCB_req   = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    ack_err    = 1'b0;
    arb_busy   = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant_a || grant_b) next_state = S_REQ;
      end
      S_REQ: begin
        SCCB_req = !timeout;
        if (timeout)     next_state = S_DONE;
        else if (busy_s) next_state = S_BUSY;
      end
      S_BUSY: begin
        if (timeout || !busy_s) next_state = S_DONE;
      end
      S_DONE: begin
        a_ack      = !owner;
        b_ack      = owner;
        ack_err    = to_err;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latch the winner and its payload at grant. They stay frozen until the next grant.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      owner   <= 1'b0;
      data_in <= 24'h0;
    end else if (state == S_IDLE && (grant_a || grant_b)) begin
      owner   <= grant_b;
      data_in <= {SLAVE_ADDR, (grant_b ? b_data : a_data)};
    end
  end

  // Round-robin pointer. It advances when a transaction completes.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      rr_last_b <= 1'b1;
    end else if (state == S_DONE) begin
      rr_last_b <= owner;
    end
  end

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Directed bench for sccb_req_arbiter. It instantiates the design with TIMEOUT_CYC=100.
// A small engine model raises SCCB_busy a few cycles after SCCB_req and holds it for eng_len cycles.
module tb_sccb_req_arbiter;

  logic        S_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done = 1'b0;
  logic        a_req = 1'b0;
  logic [15:0] a_data = 16'h0;
  logic        a_ack;
  logic        b_req = 1'b0;
  logic [15:0] b_data = 16'h0;
  logic        b_ack;
  logic        ack_err;
  logic        SCCB_req;
  logic [23:0] data_in;
  logic        SCCB_busy = 1'b0;
  logic        owner;
  logic        arb_busy;

  int checks = 0;
  int failures = 0;

  int  eng_len = 40;
  bit  eng_stuck = 1'b0;

  int  a_ack_cnt = 0;
  int  b_ack_cnt = 0;
  int  err_cnt = 0;
  int  rise_cnt = 0;
  bit  req_q = 1'b0;

  sccb_req_arbiter #(
    .SLAVE_ADDR (8'h42),
    .TIMEOUT_CYC(20'd100)
  ) dut (
    .S_CLK    (S_CLK),
    .RST      (RST),
    .init_done(init_done),
    .a_req    (a_req),
    .a_data   (a_data),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_data   (b_data),
    .b_ack    (b_ack),
    .ack_err  (ack_err),
    .SCCB_req (SCCB_req),
    .data_in  (data_in),
    .SCCB_busy(SCCB_busy),
    .owner    (owner),
    .arb_busy (arb_busy)
  );

  always #5 S_CLK = ~S_CLK;

  // Engine model: responds to SCCB_req with a busy window.
  initial begin
    forever begin
      @(negedge S_CLK);
      if (SCCB_req && !eng_stuck) begin
        repeat (2) @(negedge S_CLK);
        SCCB_busy = 1'b1;
        repeat (eng_len) @(negedge S_CLK);
        SCCB_busy = 1'b0;
        while (SCCB_req) @(negedge S_CLK);
      end
    end
  end

  // Pulse monitor: counts the acks, the errors and the SCCB_req rising edges.
  always @(posedge S_CLK) begin
    if (a_ack) a_ack_cnt = a_ack_cnt + 1;
    if (b_ack) b_ack_cnt = b_ack_cnt + 1;
    if (ack_err) err_cnt = err_cnt + 1;
    if (SCCB_req && !req_q) rise_cnt = rise_cnt + 1;
    req_q = SCCB_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = a_ack | b_ack;
    end
  endtask

  task automatic wait_busy_state(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = arb_busy && !SCCB_req;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int a0, b0, e0, r0, cyc;
    logic exp_owner [4];
    logic [23:0] exp_data [4];
    exp_owner[0] = 1'b0; exp_data[0] = 24'h421111;
    exp_owner[1] = 1'b1; exp_data[1] = 24'h422222;
    exp_owner[2] = 1'b0; exp_data[2] = 24'h421111;
    exp_owner[3] = 1'b1; exp_data[3] = 24'h422222;

    // Reset values
    repeat (3) tick();
    check("rst_sccb_req", SCCB_req, 0);
    check("rst_acks", {a_ack, b_ack, ack_err}, 0);
    check("rst_owner", owner, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_data_in", data_in, 0);
    @(negedge S_CLK) RST = 1'b0;

    // Port A write before init. a_data is changed while BUSY.
    eng_len = 40;
    a0 = a_ack_cnt; e0 = err_cnt; r0 = rise_cnt;
    @(negedge S_CLK) begin a_data = 16'h1280; a_req = 1'b1; end
    tick();
    check("a_grant_req", SCCB_req, 1);
    check("a_grant_data", data_in, 24'h421280);
    check("a_grant_owner", owner, 0);
    wait_busy_state(50, seen);
    check("a_busy_reached", seen, 1);
    @(negedge S_CLK) a_data = 16'hFFFF;
    wait_ack(100, seen);
    check("a_ack_seen", seen, 1);
    check("a_done_data_frozen", data_in, 24'h421280);
    check("a_done_err", ack_err, 0);
    @(negedge S_CLK) a_req = 1'b0;
    repeat (5) tick();
    check("a_ack_count", a_ack_cnt - a0, 1);
    check("a_req_rises", rise_cnt - r0, 1);
    check("a_err_count", err_cnt - e0, 0);

    // Port B is held off while init_done=0 and released when init completes.
    eng_len = 10;
    b0 = b_ack_cnt; r0 = rise_cnt;
    @(negedge S_CLK) begin b_data = 16'h3A04; b_req = 1'b1; end
    repeat (1000) tick();
    check("b_held_no_req", rise_cnt - r0, 0);
    check("b_held_idle", arb_busy, 0);
    @(negedge S_CLK) init_done = 1'b1;
    wait_ack(100, seen);
    check("b_ack_seen", seen, 1);
    check("b_done_owner", owner, 1);
    check("b_done_data", data_in, 24'h423A04);
    @(negedge S_CLK) b_req = 1'b0;
    repeat (5) tick();
    check("b_ack_count", b_ack_cnt - b0, 1);

    // Both ports request together. Order must alternate, starting with A because B was served last.
    a0 = a_ack_cnt; b0 = b_ack_cnt;
    @(negedge S_CLK) begin
      a_data = 16'h1111; b_data = 16'h2222; a_req = 1'b1; b_req = 1'b1;
    end
    for (int t = 0; t < 4; t++) begin
      wait_ack(100, seen);
      check("rr_ack_seen", seen, 1);
      check("rr_owner", owner, exp_owner[t]);
      check("rr_data", data_in, exp_data[t]);
      @(negedge S_CLK) begin
        if (t == 3) begin a_req = 1'b0; b_req = 1'b0; end
        else if (owner) b_req = 1'b0;
        else a_req = 1'b0;
      end
      if (t != 3) @(negedge S_CLK) begin a_req = 1'b1; b_req = 1'b1; end
    end
    repeat (5) tick();
    check("rr_a_count", a_ack_cnt - a0, 2);
    check("rr_b_count", b_ack_cnt - b0, 2);

    // Reset during BUSY: no ack is produced, and the held request restarts after release.
    eng_len = 40;
    a0 = a_ack_cnt;
    @(negedge S_CLK) begin a_data = 16'h5678; a_req = 1'b1; end
    wait_busy_state(50, seen);
    check("rst_mid_busy_reached", seen, 1);
    repeat (3) tick();
    @(negedge S_CLK) RST = 1'b1;
    tick();
    check("rst_mid_arb_busy", arb_busy, 0);
    check("rst_mid_sccb_req", SCCB_req, 0);
    check("rst_mid_outputs", {a_ack, b_ack, ack_err, owner}, 0);
    check("rst_mid_data_in", data_in, 0);
    @(negedge S_CLK) RST = 1'b0;
    check("rst_mid_no_ack", a_ack_cnt - a0, 0);
    wait_ack(200, seen);
    check("rst_mid_restart_ack", seen, 1);
    check("rst_mid_restart_data", data_in, 24'h425678);
    @(negedge S_CLK) a_req = 1'b0;
    repeat (3) tick();
    check("rst_mid_ack_count", a_ack_cnt - a0, 1);

    // Engine never goes busy.
    eng_stuck = 1'b1;
    a0 = a_ack_cnt;
    @(negedge S_CLK) begin a_data = 16'h0A0B; a_req = 1'b1; end
    tick();
    check("to_req_entry", SCCB_req, 1);
`ifdef SCCB_ARB_TIMEOUT_EN
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      cyc = cyc + 1;
      seen = a_ack;
    end
    check("to_ack_seen", seen, 1);
    check("to_ack_cycle", cyc, 101);
    check("to_ack_err", ack_err, 1);
    check("to_done_sccb_req", SCCB_req, 0);
    @(negedge S_CLK) a_req = 1'b0;
    repeat (3) tick();
    check("to_ack_count", a_ack_cnt - a0, 1);
`else
    cyc = 0;
    repeat (300) tick();
    check("to_off_no_ack", a_ack_cnt - a0, 0);
    check("to_off_still_busy", arb_busy, 1);
    check("to_off_sccb_req", SCCB_req, 1);
    @(negedge S_CLK) begin a_req = 1'b0; RST = 1'b1; end
    tick();
    @(negedge S_CLK) RST = 1'b0;
    tick();
    check("to_off_recovered", arb_busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_req_arbiter.md
SCCB_REQ_ARBITER -- requirements
Module: sccb_req_arbiter

Interface
REQ-001 Parameter SLAVE_ADDR, default 8'h42: SCCB write address prefixed to every transaction.
REQ-002 Parameter TIMEOUT_CYC, default 20'd600000: S_CLK cycles allowed per transaction (used only with SCCB_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 S_CLK  in  1  system clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 init_done  in  1  level; high once the init LUT sequence has finished.
REQ-007 a_req  in  1  init-sequencer request, level, held until a_ack.
REQ-008 a_data  in  16  {reg addr, reg value} for port A, stable while a_req high.
REQ-009 a_ack  out  1  one-cycle completion pulse, port A.
REQ-010 b_req  in  1  runtime-control request, level, held until b_ack.
REQ-011 b_data  in  16  {reg addr, reg value} for port B, stable while b_req high.
REQ-012 b_ack  out  1  one-cycle completion pulse, port B.
REQ-013 ack_err  out  1  high together with a_ack/b_ack when the transaction timed out.
REQ-014 SCCB_req  out  1  request level to the SCCB write engine.
REQ-015 data_in  out  24  {SLAVE_ADDR, selected data} to the SCCB write engine.
REQ-016 SCCB_busy  in  1  engine busy flag, asynchronous to S_CLK (slow divided-clock domain).
REQ-017 owner  out  1  0 = port A granted, 1 = port B granted; valid while arb_busy.
REQ-018 arb_busy  out  1  high in any state other than IDLE.

Function
REQ-019 SCCB_busy SHALL pass through a 2-flop synchronizer (busy_s) before use; no other logic sees raw SCCB_busy.
REQ-020 FSM states: IDLE, REQ, BUSY, DONE.
REQ-021 IDLE: a request is sampled; on grant, latch owner and data_in, go to REQ next cycle; otherwise stay.
REQ-022 Grant rule while init_done=0: only port A is grantable; b_req is held off indefinitely.
REQ-023 Grant rule while init_done=1: single requester wins; both requesting -> the port not served last wins (round-robin pointer, reset value = B last, so A wins first tie).
REQ-024 REQ: SCCB_req=1; on busy_s=1 go to BUSY.
REQ-025 BUSY: SCCB_req=0; on busy_s=0 go to DONE.
REQ-026 DONE: exactly one cycle; pulse ack of owner, update round-robin pointer, return to IDLE.
REQ-027 Requesters SHALL drop req on the edge where ack is sampled high; arbiter samples req again only in IDLE, so one held request yields exactly one transaction.
REQ-028 data_in and owner SHALL remain constant from grant until DONE exit, regardless of requester data changes.
REQ-029 A requester dropping req before its ack SHALL NOT abort the transaction; ack is still pulsed.
REQ-030 Grant latency: data_in valid and SCCB_req high 1 cycle after req sampled in IDLE.

Reset
REQ-031 On RST: state=IDLE, SCCB_req=0, a_ack=0, b_ack=0, ack_err=0, owner=0, arb_busy=0, data_in=24'h0, synchronizer flops=0, round-robin pointer=B, timeout counter=0.
REQ-032 RST mid-transaction SHALL abandon it without any ack pulse; pending requests re-arbitrate after reset.

Configuration
REQ-033 Macro SCCB_ARB_TIMEOUT_EN defined: 20-bit counter clears on entry to REQ, counts in REQ and BUSY; reaching TIMEOUT_CYC forces DONE with ack_err=1 and SCCB_req=0.
REQ-034 Macro SCCB_ARB_TIMEOUT_EN undefined: no counter, ack_err tied 0, REQ/BUSY wait indefinitely.

Verification
REQ-035 init_done=0, a_req=1 a_data=16'h1280, engine busy 40 cycles -> data_in=24'h421280, SCCB_req high until busy_s, single a_ack, ack_err=0.
REQ-036 init_done=0, b_req=1 only -> no SCCB_req for 1000 cycles; set init_done=1 -> b transaction, single b_ack.
REQ-037 init_done=1, a_req and b_req held together for 4 transactions -> order A,B,A,B.
REQ-038 RST asserted during BUSY -> all outputs at reset values next cycle, no ack; transaction restarts after RST release.
REQ-039 TIMEOUT_CYC=100, SCCB_busy stuck 0, macro defined -> a_ack with ack_err=1 at cycle 101 after REQ entry; macro undefined -> no ack.
REQ-040 a_data changed while in BUSY -> data_in unchanged until DONE.
